// File: rtl/input_conditioner.sv
// input_conditioner
// Two-channel input conditioner feeding the exercise FSMs. Each raw input is
// optionally passed through a two-flop synchroniser, debounced by a stability
// counter and presented as a clean level plus single-cycle rise/fall pulses.
// Channels A and B are identical and independent.
//
// Build option:
//   INPUT_COND_SYNC_EN  defined   -> two-flop synchroniser per channel
//                       undefined -> raw input feeds the comparator directly
//                                    (only for inputs already synchronous to clk)
//
// Parameters:
//   DEB_CYCLES  cycles a new level must be held before it is accepted
//               (1 .. 2**CNT_W-1)
//   CNT_W       width of each debounce counter
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high; clears all state
//   a_raw, b_raw  raw asynchronous inputs
//   a_out, b_out  debounced levels
//   a_rise/a_fall one-cycle pulses on a_out 0->1 / 1->0
//   b_rise/b_fall one-cycle pulses on b_out 0->1 / 1->0
module input_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_out,
  output logic b_out,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEB_CYCLES - 1);

  // Bit 0 is channel A, bit 1 is channel B.
  logic [1:0]       raw_w;
  logic [1:0]       samp_w;
  logic [1:0]       lvl_q, lvl_d;
  logic [1:0]       rise_q, rise_d;
  logic [1:0]       fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign raw_w = {b_raw, a_raw};

`ifdef INPUT_COND_SYNC_EN
  logic [1:0] s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_w;
      s2_q <= s1_q;
    end
  end

  assign samp_w = s2_q;
`else
  assign samp_w = raw_w;
`endif

  // A differing sample must be seen on DEB_CYCLES consecutive edges; any
  // sample matching the accepted level throws away the partial count.
  always_comb begin
    lvl_d  = lvl_q;
    rise_d = '0;
    fall_d = '0;
    for (int ch = 0; ch < 2; ch++) begin
      cnt_d[ch] = '0;
      if (samp_w[ch] != lvl_q[ch]) begin
        if (cnt_q[ch] == CNT_TERM) begin
          lvl_d[ch]  = samp_w[ch];
          rise_d[ch] = samp_w[ch];
          fall_d[ch] = ~samp_w[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int ch = 0; ch < 2; ch++) cnt_q[ch] <= '0;
    end else begin
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int ch = 0; ch < 2; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  assign a_out  = lvl_q[0];
  assign b_out  = lvl_q[1];
  assign a_rise = rise_q[0];
  assign a_fall = fall_q[0];
  assign b_rise = rise_q[1];
  assign b_fall = fall_q[1];

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int DEB = 4;
  localparam int N   = 4096;
`ifdef INPUT_COND_SYNC_EN
  localparam int LAT = DEB + 2;
`else
  localparam int LAT = DEB;
`endif

  logic clk = 1'b0;
  logic reset, a_raw, b_raw;
  logic a_out, b_out, a_rise, a_fall, b_rise, b_fall;

  input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw),
    .a_out(a_out), .b_out(b_out), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Directed expectations written by the stimulus process.
  int pin_edge = -10;
  bit pin_val = 1'b0;
  bit pin_b = 1'b0;
  bit b_quiet = 1'b0;

  // Model: per-edge history of comparator samples, reset edges and raw inputs.
  bit c_h   [2][N];
  bit e_h   [2][N];
  bit rst_h [N];
  bit m_lvl [2];
  bit m_rise[2];
  bit m_fall[2];
  int last_flip[2];
  bit model_ok = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_cnt, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    int n;
    bit r, c, acc;
    edge_cnt++;
    n = edge_cnt;
    rst_h[n % N] = reset;
    if (reset) model_ok = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      r = (ch == 0) ? a_raw : b_raw;
      if (reset) begin
        m_lvl[ch] = 1'b0; m_rise[ch] = 1'b0; m_fall[ch] = 1'b0;
        last_flip[ch] = n;
        e_h[ch][n % N] = 1'b0;
        c_h[ch][n % N] = 1'b0;
      end else begin
        e_h[ch][n % N] = r;
`ifdef INPUT_COND_SYNC_EN
        // Sample seen now is the raw value two edges ago, zeroed by a reset in between.
        c = (n < 3 || rst_h[(n - 1) % N]) ? 1'b0 : e_h[ch][(n - 2) % N];
`else
        c = r;
`endif
        c_h[ch][n % N] = c;
        // Accept when the last DEB samples since the previous change/reset all differ.
        acc = (n - DEB + 1 > last_flip[ch]);
        if (acc)
          for (int j = 0; j < DEB; j++)
            if (c_h[ch][(n - j) % N] == m_lvl[ch]) acc = 1'b0;
        if (acc) begin
          m_lvl[ch] = c; m_rise[ch] = c; m_fall[ch] = ~c;
          last_flip[ch] = n;
        end else begin
          m_rise[ch] = 1'b0; m_fall[ch] = 1'b0;
        end
      end
    end
    #1;
    if (model_ok) begin
      chk("a_out",  int'(a_out),  int'(m_lvl[0]));
      chk("a_rise", int'(a_rise), int'(m_rise[0]));
      chk("a_fall", int'(a_fall), int'(m_fall[0]));
      chk("b_out",  int'(b_out),  int'(m_lvl[1]));
      chk("b_rise", int'(b_rise), int'(m_rise[1]));
      chk("b_fall", int'(b_fall), int'(m_fall[1]));
      if (edge_cnt == pin_edge - 1) begin
        chk("pin_pre_a_out", int'(a_out), int'(!pin_val));
        chk("pin_pre_model_a", int'(m_lvl[0]), int'(!pin_val));
        if (pin_b) chk("pin_pre_b_out", int'(b_out), int'(!pin_val));
      end
      if (edge_cnt == pin_edge) begin
        chk("pin_a_out", int'(a_out), int'(pin_val));
        chk("pin_model_a", int'(m_lvl[0]), int'(pin_val));
        chk("pin_a_pulse", int'(pin_val ? a_rise : a_fall), 1);
        if (pin_b) begin
          chk("pin_b_out", int'(b_out), int'(pin_val));
          chk("pin_b_pulse", int'(pin_val ? b_rise : b_fall), 1);
        end
      end
      if (edge_cnt == pin_edge + 1) begin
        chk("pin_a_pulse_end", int'(a_rise | a_fall), 0);
        if (pin_b) chk("pin_b_pulse_end", int'(b_rise | b_fall), 0);
      end
      if (b_quiet) begin
        chk("quiet_b_out", int'(b_out), 0);
        chk("quiet_b_rise", int'(b_rise), 0);
        chk("quiet_model_b", int'(m_lvl[1]), 0);
      end
    end
  end

  initial begin
    reset = 1'b1; a_raw = 1'b0; b_raw = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(20);

    // Single channel rise then fall.
    a_raw = 1'b1; pin_val = 1'b1; pin_b = 1'b0; pin_edge = edge_cnt + LAT;
    cyc(LAT + 3);
    a_raw = 1'b0; pin_val = 1'b0; pin_edge = edge_cnt + LAT;
    cyc(LAT + 3);

    // Glitches shorter than DEB are rejected.
    b_quiet = 1'b1;
    b_raw = 1'b1; cyc(DEB - 1);
    b_raw = 1'b0; cyc(1);
    b_raw = 1'b1; cyc(DEB - 1);
    b_raw = 1'b0; cyc(LAT + 2);
    b_quiet = 1'b0;

    // Pulse of exactly DEB cycles is accepted.
    b_raw = 1'b1; cyc(DEB);
    b_raw = 1'b0; cyc(LAT + 6);

    // Both channels together.
    a_raw = 1'b1; b_raw = 1'b1; pin_val = 1'b1; pin_b = 1'b1; pin_edge = edge_cnt + LAT;
    cyc(LAT + 3);
    a_raw = 1'b0; b_raw = 1'b0; pin_val = 1'b0; pin_edge = edge_cnt + LAT;
    cyc(LAT + 3);
    pin_b = 1'b0;

    // Reset while the counter sits at 2; counting restarts after release.
    a_raw = 1'b1;
    cyc(LAT - 2);
    reset = 1'b1; pin_val = 1'b1; pin_edge = edge_cnt + 1 + LAT;
    cyc(1);
    reset = 1'b0;
    cyc(LAT + 3);
    a_raw = 1'b0;
    cyc(LAT + 3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) a_raw = ~a_raw;
      if ($urandom_range(7) == 0) b_raw = ~b_raw;
      reset = ($urandom_range(249) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
